aq_dtu_halt_ctrl: RTL and testbench
===================================

AQ_DTU_HALT_CTRL -- requirements
Module: aq_dtu_halt_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports (name, direction, width, meaning):
- forever_cpuclk  in  1  – clock.
- cpurst  in  1  – synchronous active-high reset.
- had_dtu_haltreq  in  1  – level halt request from debug module.
- had_dtu_resumereq  in  1  – one-cycle resume pulse.
- had_dtu_step  in  1  – dcsr.step.
- rtu_dtu_retire_vld  in  1  – instruction retired.
- rtu_dtu_retire_halt_info  in  22  – retire trigger-hit info; nonzero = debug-action trigger hit.
- rtu_dtu_retire_ebreak  in  1  – retired ebreak with ebreak-to-debug enabled.
- pending_halt  in  1  – trigger-module pending (after-timing/icount) halt.
- dtu_cause  in  4  – trigger-module cause code.
- rtu_dtu_halt_ack  in  1  – RTU accepted halt request.
- rtu_dtu_pending_ack  in  1  – RTU accepted pending request.
- rtu_yy_xx_dbgon  in  1  – core is in debug mode.
- dtu_rtu_async_halt_req  out  1  – asynchronous halt request.
- dtu_rtu_sync_halt_req  out  1  – synchronous (retire-attached) halt request.
- dtu_rtu_pending_halt_req  out  1  – pending halt request.
- dtu_rtu_resume_req  out  1  – resume request.
- dtu_had_halted  out  1  – halted status.
- dtu_had_resumeack  out  1  – one-cycle resume acknowledge.
- dtu_dcsr_cause  out  3  – dcsr.cause.
- dtu_trig_cause  out  4  – captured dtu_cause.

Function
REQ-003 SHALL implement a 4-state FSM: RUN, HALT_REQ, HALTED, RESUME.
REQ-004 In RUN, SHALL select one entry event per cycle, highest first:
- trigger: retire_vld && halt_info!=0; cause 2; sync.
- ebreak: retire_vld && retire_ebreak; cause 1; sync.
- pending: cause 2; pending path.
- step: step_armed && retire_vld; cause 4; sync.
- haltreq: cause 3; async.
REQ-005 Selected event SHALL move RUN->HALT_REQ and load dtu_dcsr_cause on the next edge; the matching request output SHALL assert in that cycle (1-cycle latency).
REQ-006 On trigger entry, dtu_trig_cause SHALL load dtu_cause; it SHALL hold otherwise.
REQ-007 Pending path: dtu_rtu_pending_halt_req SHALL stay high until rtu_dtu_pending_ack; on ack it SHALL drop next cycle and dtu_rtu_sync_halt_req SHALL assert, cause unchanged.
REQ-008 In HALT_REQ, the active request SHALL stay high until rtu_dtu_halt_ack; the FSM SHALL then go to HALTED with the request low on the next edge.
REQ-009 dtu_had_halted SHALL equal (state==HALTED) && rtu_yy_xx_dbgon.
REQ-010 had_dtu_resumereq in HALTED SHALL move the FSM to RESUME; dtu_rtu_resume_req SHALL be high throughout RESUME.
REQ-011 In RESUME, rtu_yy_xx_dbgon low SHALL move the FSM to RUN and pulse dtu_had_resumeack for exactly one cycle.
REQ-012 step_armed SHALL set on the RESUME->RUN edge when had_dtu_step=1, clear on the first retire_vld in RUN, and clear on any HALT_REQ entry.
REQ-013 had_dtu_resumereq outside HALTED SHALL be ignored.
REQ-014 New events in HALT_REQ/HALTED/RESUME SHALL be ignored, and cause SHALL not change; had_dtu_haltreq still high on RESUME->RUN SHALL be honoured by the next edge.
REQ-015 At most one of the async, sync and pending request outputs SHALL be high in any cycle.

Reset
REQ-016 While cpurst=1 at an edge: state=RUN; all request outputs, dtu_had_halted, dtu_had_resumeack and step_armed =0; dtu_dcsr_cause=0; dtu_trig_cause=0.
REQ-017 Reset asserted in any state SHALL abort the operation in progress with no acknowledge pulse.

Verification
REQ-018 haltreq=1 in RUN -> async_req=1 next cycle; halt_ack -> HALTED, cause=3; with dbgon=1, halted=1.
REQ-019 retire_vld, halt_info=22'h1, dtu_cause=4'h5 -> sync_req next cycle, cause=2, trig_cause=5.
REQ-020 Same-cycle trigger hit + haltreq + ebreak -> cause=2, sync only; async never asserts.
REQ-021 pending_halt=1 -> pending_req until pending_ack; then sync_req=1; halt_ack -> HALTED with cause=2.
REQ-022 HALTED, step=1, resumereq -> resume_req until dbgon=0; resumeack one cycle; first retire -> sync_req, cause=4.
REQ-023 cpurst asserted in HALT_REQ -> all outputs 0 and state RUN on the next edge; no resumeack pulse.

Source files
------------

// File: rtl/aq_dtu_halt_ctrl.sv
// Debug halt/resume controller: arbitrates halt-entry events in RUN, hands the
// selected request to the RTU, tracks halted state and runs the resume handshake.
module aq_dtu_halt_ctrl (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        had_dtu_haltreq,
    input  logic        had_dtu_resumereq,
    input  logic        had_dtu_step,
    input  logic        rtu_dtu_retire_vld,
    input  logic [21:0] rtu_dtu_retire_halt_info,
    input  logic        rtu_dtu_retire_ebreak,
    input  logic        pending_halt,
    input  logic [3:0]  dtu_cause,
    input  logic        rtu_dtu_halt_ack,
    input  logic        rtu_dtu_pending_ack,
    input  logic        rtu_yy_xx_dbgon,
    output logic        dtu_rtu_async_halt_req,
    output logic        dtu_rtu_sync_halt_req,
    output logic        dtu_rtu_pending_halt_req,
    output logic        dtu_rtu_resume_req,
    output logic        dtu_had_halted,
    output logic        dtu_had_resumeack,
    output logic [2:0]  dtu_dcsr_cause,
    output logic [3:0]  dtu_trig_cause
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALT_REQ = 2'd1,
        HALTED   = 2'd2,
        RESUME   = 2'd3
    } state_t;

    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    state_t      state_reg, state_next;
    logic        async_req_reg, async_req_next;
    logic        sync_req_reg, sync_req_next;
    logic        pend_req_reg, pend_req_next;
    logic        resumeack_reg, resumeack_next;
    logic        step_armed_reg, step_armed_next;
    logic [2:0]  cause_reg, cause_next;
    logic [3:0]  trig_cause_reg, trig_cause_next;

    logic trig_hit, ebreak_hit, step_hit;

    assign trig_hit   = rtu_dtu_retire_vld && (|rtu_dtu_retire_halt_info);
    assign ebreak_hit = rtu_dtu_retire_vld && rtu_dtu_retire_ebreak;
    assign step_hit   = step_armed_reg && rtu_dtu_retire_vld;

    always_comb begin
        state_next      = state_reg;
        async_req_next  = async_req_reg;
        sync_req_next   = sync_req_reg;
        pend_req_next   = pend_req_reg;
        resumeack_next  = 1'b0;
        step_armed_next = step_armed_reg;
        cause_next      = cause_reg;
        trig_cause_next = trig_cause_reg;

        case (state_reg)
            RUN: begin
                // Priority: trigger > ebreak > pending > step > haltreq
                if (trig_hit) begin
                    state_next      = HALT_REQ;
                    sync_req_next   = 1'b1;
                    cause_next      = CAUSE_TRIGGER;
                    trig_cause_next = dtu_cause;
                end else if (ebreak_hit) begin
                    state_next    = HALT_REQ;
                    sync_req_next = 1'b1;
                    cause_next    = CAUSE_EBREAK;
                end else if (pending_halt) begin
                    state_next    = HALT_REQ;
                    pend_req_next = 1'b1;
                    cause_next    = CAUSE_TRIGGER;
                end else if (step_hit) begin
                    state_next    = HALT_REQ;
                    sync_req_next = 1'b1;
                    cause_next    = CAUSE_STEP;
                end else if (had_dtu_haltreq) begin
                    state_next     = HALT_REQ;
                    async_req_next = 1'b1;
                    cause_next     = CAUSE_HALTREQ;
                end

                if (state_next == HALT_REQ || rtu_dtu_retire_vld)
                    step_armed_next = 1'b0;
            end
            HALT_REQ: begin
                // A pending request converts to a sync request once the RTU takes it
                if (pend_req_reg) begin
                    if (rtu_dtu_pending_ack) begin
                        pend_req_next = 1'b0;
                        sync_req_next = 1'b1;
                    end
                end else if (rtu_dtu_halt_ack) begin
                    state_next     = HALTED;
                    async_req_next = 1'b0;
                    sync_req_next  = 1'b0;
                end
            end
            HALTED: begin
                if (had_dtu_resumereq)
                    state_next = RESUME;
            end
            RESUME: begin
                if (!rtu_yy_xx_dbgon) begin
                    state_next      = RUN;
                    resumeack_next  = 1'b1;
                    step_armed_next = had_dtu_step;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_reg      <= RUN;
            async_req_reg  <= 1'b0;
            sync_req_reg   <= 1'b0;
            pend_req_reg   <= 1'b0;
            resumeack_reg  <= 1'b0;
            step_armed_reg <= 1'b0;
            cause_reg      <= 3'd0;
            trig_cause_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            async_req_reg  <= async_req_next;
            sync_req_reg   <= sync_req_next;
            pend_req_reg   <= pend_req_next;
            resumeack_reg  <= resumeack_next;
            step_armed_reg <= step_armed_next;
            cause_reg      <= cause_next;
            trig_cause_reg <= trig_cause_next;
        end
    end

    assign dtu_rtu_async_halt_req   = async_req_reg;
    assign dtu_rtu_sync_halt_req    = sync_req_reg;
    assign dtu_rtu_pending_halt_req = pend_req_reg;
    assign dtu_rtu_resume_req       = (state_reg == RESUME);
    assign dtu_had_halted           = (state_reg == HALTED) && rtu_yy_xx_dbgon;
    assign dtu_had_resumeack        = resumeack_reg;
    assign dtu_dcsr_cause           = cause_reg;
    assign dtu_trig_cause           = trig_cause_reg;

endmodule

// File: tb/tb_aq_dtu_halt_ctrl.sv
// Directed bench for aq_dtu_halt_ctrl: one task per scenario, inline checks.
module tb_aq_dtu_halt_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        haltreq, resumereq, step, retire_vld, ebreak, pending_halt;
    logic [21:0] halt_info;
    logic [3:0]  dtu_cause;
    logic        halt_ack, pending_ack, dbgon;
    logic        async_req, sync_req, pend_req, resume_req, halted, resumeack;
    logic [2:0]  dcsr_cause;
    logic [3:0]  trig_cause;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    aq_dtu_halt_ctrl dut (
        .forever_cpuclk          (clk),
        .cpurst                  (cpurst),
        .had_dtu_haltreq         (haltreq),
        .had_dtu_resumereq       (resumereq),
        .had_dtu_step            (step),
        .rtu_dtu_retire_vld      (retire_vld),
        .rtu_dtu_retire_halt_info(halt_info),
        .rtu_dtu_retire_ebreak   (ebreak),
        .pending_halt            (pending_halt),
        .dtu_cause               (dtu_cause),
        .rtu_dtu_halt_ack        (halt_ack),
        .rtu_dtu_pending_ack     (pending_ack),
        .rtu_yy_xx_dbgon         (dbgon),
        .dtu_rtu_async_halt_req  (async_req),
        .dtu_rtu_sync_halt_req   (sync_req),
        .dtu_rtu_pending_halt_req(pend_req),
        .dtu_rtu_resume_req      (resume_req),
        .dtu_had_halted          (halted),
        .dtu_had_resumeack       (resumeack),
        .dtu_dcsr_cause          (dcsr_cause),
        .dtu_trig_cause          (trig_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: acknowledge the outstanding halt and enter debug mode
    task automatic do_halt_ack();
        halt_ack = 1'b1; dbgon = 1'b1;
        tick();
        halt_ack = 1'b0;
    endtask

    // Stimulus only: resume from HALTED back to RUN
    task automatic do_resume();
        resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        dbgon = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        tick(); tick();
        tests++; if ({async_req, sync_req, pend_req} !== 3'b000) begin failed++;
            $display("FAIL reset_reqs: got %b want 000", {async_req, sync_req, pend_req}); end
        tests++; if ({resume_req, halted, resumeack} !== 3'b000) begin failed++;
            $display("FAIL reset_status: got %b want 000", {resume_req, halted, resumeack}); end
        tests++; if (dcsr_cause !== 3'd0 || trig_cause !== 4'd0) begin failed++;
            $display("FAIL reset_cause: got %0d/%0d want 0/0", dcsr_cause, trig_cause); end
        cpurst = 1'b0;
        tick();
        $display("[TB] reset: reqs=%b cause=%0d", {async_req, sync_req, pend_req}, dcsr_cause);
    endtask

    task automatic test_haltreq();
        haltreq = 1'b1;
        tick();
        haltreq = 1'b0;
        tests++; if (async_req !== 1'b1 || sync_req !== 1'b0) begin failed++;
            $display("FAIL haltreq_async: got a=%b s=%b want a=1 s=0", async_req, sync_req); end
        tests++; if (dcsr_cause !== 3'd3) begin failed++;
            $display("FAIL haltreq_cause: got %0d want 3", dcsr_cause); end
        tick();
        tests++; if (async_req !== 1'b1) begin failed++;
            $display("FAIL haltreq_hold: got %b want 1", async_req); end
        resumereq = 1'b1;                   // ignored outside HALTED
        tick();
        resumereq = 1'b0;
        do_halt_ack();
        tests++; if (async_req !== 1'b0 || halted !== 1'b1 || dcsr_cause !== 3'd3) begin failed++;
            $display("FAIL haltreq_halted: got a=%b h=%b c=%0d want a=0 h=1 c=3", async_req, halted, dcsr_cause); end
        dbgon = 1'b0;
        tick();
        tests++; if (halted !== 1'b0) begin failed++;
            $display("FAIL halted_needs_dbgon: got %b want 0", halted); end
        dbgon = 1'b1;
        resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        tests++; if (resume_req !== 1'b1 || halted !== 1'b0) begin failed++;
            $display("FAIL resume_req: got r=%b h=%b want r=1 h=0", resume_req, halted); end
        tick();
        tests++; if (resume_req !== 1'b1 || resumeack !== 1'b0) begin failed++;
            $display("FAIL resume_hold: got r=%b ack=%b want r=1 ack=0", resume_req, resumeack); end
        dbgon = 1'b0;
        tick();
        tests++; if (resume_req !== 1'b0 || resumeack !== 1'b1) begin failed++;
            $display("FAIL resumeack_pulse: got r=%b ack=%b want r=0 ack=1", resume_req, resumeack); end
        tick();
        tests++; if (resumeack !== 1'b0 || async_req !== 1'b0) begin failed++;
            $display("FAIL resumeack_single: got ack=%b a=%b want 0 0", resumeack, async_req); end
        $display("[TB] haltreq: cause=%0d", dcsr_cause);
    endtask

    task automatic test_trigger();
        retire_vld = 1'b1; halt_info = 22'h1; dtu_cause = 4'h5;
        tick();
        retire_vld = 1'b0; halt_info = 22'h0; dtu_cause = 4'h0;
        tests++; if (sync_req !== 1'b1 || async_req !== 1'b0 || pend_req !== 1'b0) begin failed++;
            $display("FAIL trig_sync: got %b want 010", {async_req, sync_req, pend_req}); end
        tests++; if (dcsr_cause !== 3'd2 || trig_cause !== 4'h5) begin failed++;
            $display("FAIL trig_cause: got %0d/%0d want 2/5", dcsr_cause, trig_cause); end
        do_halt_ack();
        tests++; if (halted !== 1'b1 || sync_req !== 1'b0) begin failed++;
            $display("FAIL trig_halted: got h=%b s=%b want 1 0", halted, sync_req); end
        do_resume();
        $display("[TB] trigger: trig_cause=%0d", trig_cause);
    endtask

    task automatic test_priority();
        retire_vld = 1'b1; halt_info = 22'h3; haltreq = 1'b1; ebreak = 1'b1; dtu_cause = 4'h9;
        tick();
        retire_vld = 1'b0; halt_info = 22'h0; ebreak = 1'b0; dtu_cause = 4'h0;
        tests++; if ({async_req, sync_req, pend_req} !== 3'b010 || dcsr_cause !== 3'd2) begin failed++;
            $display("FAIL prio_trig: got %b c=%0d want 010 c=2", {async_req, sync_req, pend_req}, dcsr_cause); end
        tick(); tick();                     // haltreq still high in HALT_REQ
        tests++; if (async_req !== 1'b0 || dcsr_cause !== 3'd2 || trig_cause !== 4'h9) begin failed++;
            $display("FAIL prio_no_async: got a=%b c=%0d t=%0d want 0 2 9", async_req, dcsr_cause, trig_cause); end
        do_halt_ack();
        resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        dbgon = 1'b0;
        tick();
        tests++; if (resumeack !== 1'b1) begin failed++;
            $display("FAIL prio_resumeack: got %b want 1", resumeack); end
        tests++; if (async_req !== 1'b0) begin failed++;
            $display("FAIL prio_async_early: got %b want 0", async_req); end
        tick();                             // haltreq still high: honoured now
        haltreq = 1'b0;
        tests++; if (async_req !== 1'b1 || dcsr_cause !== 3'd3) begin failed++;
            $display("FAIL haltreq_after_resume: got a=%b c=%0d want 1 3", async_req, dcsr_cause); end
        do_halt_ack();
        do_resume();
        $display("[TB] priority: cause=%0d", dcsr_cause);
    endtask

    task automatic test_ebreak();
        retire_vld = 1'b1; ebreak = 1'b1; pending_halt = 1'b1; dtu_cause = 4'hC;
        tick();
        retire_vld = 1'b0; ebreak = 1'b0; pending_halt = 1'b0; dtu_cause = 4'h0;
        tests++; if ({async_req, sync_req, pend_req} !== 3'b010 || dcsr_cause !== 3'd1) begin failed++;
            $display("FAIL ebreak: got %b c=%0d want 010 c=1", {async_req, sync_req, pend_req}, dcsr_cause); end
        tests++; if (trig_cause !== 4'h9) begin failed++;
            $display("FAIL ebreak_trig_hold: got %0d want 9", trig_cause); end
        do_halt_ack();
        do_resume();
        $display("[TB] ebreak: cause=%0d", dcsr_cause);
    endtask

    task automatic test_pending();
        pending_halt = 1'b1; haltreq = 1'b1; dtu_cause = 4'h7;
        tick();
        pending_halt = 1'b0; haltreq = 1'b0; dtu_cause = 4'h0;
        tests++; if ({async_req, sync_req, pend_req} !== 3'b001 || dcsr_cause !== 3'd2) begin failed++;
            $display("FAIL pend_req: got %b c=%0d want 001 c=2", {async_req, sync_req, pend_req}, dcsr_cause); end
        halt_ack = 1'b1;                    // halt_ack does not retire a pending request
        tick();
        halt_ack = 1'b0;
        tests++; if (pend_req !== 1'b1 || sync_req !== 1'b0) begin failed++;
            $display("FAIL pend_hold: got p=%b s=%b want 1 0", pend_req, sync_req); end
        pending_ack = 1'b1;
        tick();
        pending_ack = 1'b0;
        tests++; if ({async_req, sync_req, pend_req} !== 3'b010 || dcsr_cause !== 3'd2) begin failed++;
            $display("FAIL pend_to_sync: got %b c=%0d want 010 c=2", {async_req, sync_req, pend_req}, dcsr_cause); end
        do_halt_ack();
        tests++; if (halted !== 1'b1 || sync_req !== 1'b0 || dcsr_cause !== 3'd2) begin failed++;
            $display("FAIL pend_halted: got h=%b s=%b c=%0d want 1 0 2", halted, sync_req, dcsr_cause); end
        $display("[TB] pending: cause=%0d trig=%0d", dcsr_cause, trig_cause);
    endtask

    // Starts in HALTED (left there by test_pending)
    task automatic test_step();
        step = 1'b1;
        resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        tests++; if (resume_req !== 1'b1) begin failed++;
            $display("FAIL step_resume_req: got %b want 1", resume_req); end
        dbgon = 1'b0;
        tick();
        step = 1'b0;
        tests++; if (resumeack !== 1'b1 || resume_req !== 1'b0) begin failed++;
            $display("FAIL step_resumeack: got ack=%b r=%b want 1 0", resumeack, resume_req); end
        tick();
        tests++; if (sync_req !== 1'b0 || resumeack !== 1'b0) begin failed++;
            $display("FAIL step_idle: got s=%b ack=%b want 0 0", sync_req, resumeack); end
        retire_vld = 1'b1;
        tick();
        retire_vld = 1'b0;
        tests++; if (sync_req !== 1'b1 || dcsr_cause !== 3'd4) begin failed++;
            $display("FAIL step_halt: got s=%b c=%0d want 1 4", sync_req, dcsr_cause); end
        do_halt_ack();
        do_resume();
        retire_vld = 1'b1;                  // not armed: no halt
        tick();
        retire_vld = 1'b0;
        tests++; if (sync_req !== 1'b0 || dcsr_cause !== 3'd4) begin failed++;
            $display("FAIL step_disarmed: got s=%b c=%0d want 0 4", sync_req, dcsr_cause); end
        $display("[TB] step: cause=%0d", dcsr_cause);
    endtask

    task automatic test_reset_in_halt_req();
        haltreq = 1'b1;
        tick();
        haltreq = 1'b0;
        tests++; if (async_req !== 1'b1) begin failed++;
            $display("FAIL rst_setup: got %b want 1", async_req); end
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        tests++; if ({async_req, sync_req, pend_req, resume_req, halted, resumeack} !== 6'b0) begin failed++;
            $display("FAIL rst_abort: got %b want 000000",
                     {async_req, sync_req, pend_req, resume_req, halted, resumeack}); end
        tests++; if (dcsr_cause !== 3'd0 || trig_cause !== 4'd0) begin failed++;
            $display("FAIL rst_abort_cause: got %0d/%0d want 0/0", dcsr_cause, trig_cause); end
        tick();
        tests++; if (resumeack !== 1'b0 || async_req !== 1'b0) begin failed++;
            $display("FAIL rst_no_ack: got ack=%b a=%b want 0 0", resumeack, async_req); end
        halt_ack = 1'b1; dbgon = 1'b1;      // stray ack in RUN must not halt
        tick();
        halt_ack = 1'b0; dbgon = 1'b0;
        tests++; if (halted !== 1'b0) begin failed++;
            $display("FAIL rst_in_run: got %b want 0", halted); end
        $display("[TB] reset_in_halt_req: reqs=%b", {async_req, sync_req, pend_req});
    endtask

    // Any cycle with two request outputs high is an error
    always @(negedge clk) begin
        if (!cpurst && (32'(async_req) + 32'(sync_req) + 32'(pend_req)) > 1) begin
            failed++;
            $display("FAIL onehot_reqs: got %b want at most one", {async_req, sync_req, pend_req});
        end
    end

    initial begin
        cpurst = 1'b1; haltreq = 1'b0; resumereq = 1'b0; step = 1'b0;
        retire_vld = 1'b0; halt_info = 22'h0; ebreak = 1'b0; pending_halt = 1'b0;
        dtu_cause = 4'h0; halt_ack = 1'b0; pending_ack = 1'b0; dbgon = 1'b0;
        test_reset();
        test_haltreq();
        test_trigger();
        test_priority();
        test_ebreak();
        test_pending();
        test_step();
        test_reset_in_halt_req();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
